// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed seven-segment scan driver:
//   - scan FSM state encoding (BLANK / DRIVE)
//   - active-low segment patterns {g,f,e,d,c,b,a} for 0-9, the '-' code and
//     the all-off pattern
//   - helper functions for digit validity checking and anode selection
// No ports (package).
// -----------------------------------------------------------------------------
package seg7_pkg;

   // Scan state: BLANK is the one-cycle anti-ghosting gap between digits.
   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   // All anodes released (active-low).
   localparam logic [3:0] AN_OFF   = 4'hF;

   // True when a nibble is not a legal BCD digit.
   function automatic logic nibble_invalid(input logic [3:0] nib);
      return (nib > 4'd9);
   endfunction

   // True when any of the four nibbles is not a legal BCD digit.
   function automatic logic has_invalid_digit(input logic [15:0] digits);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bad = bad | nibble_invalid(digits[4*i +: 4]);
      end
      return bad;
   endfunction

   // Active-low one-cold anode pattern for a scan index.
   function automatic logic [3:0] anode_for(input logic [1:0] idx);
      logic [3:0] an_v;
      case (idx)
         2'd0:    an_v = 4'b1110;
         2'd1:    an_v = 4'b1101;
         2'd2:    an_v = 4'b1011;
         2'd3:    an_v = 4'b0111;
         default: an_v = AN_OFF;
      endcase
      return an_v;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD to seven-segment decoder. Digits 0-9 map to the
// standard active-low patterns; codes 10-15 show a dash so that corrupt data
// is visible on the display rather than silently misread.
// Ports:
//   bcd    in   4  digit code
//   seg_n  out  7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   // Digit code to segment pattern lookup.
   always_comb begin
      seg_n = SEG_DASH;
      case (bcd)
         4'd0:    seg_n = SEG_0;
         4'd1:    seg_n = SEG_1;
         4'd2:    seg_n = SEG_2;
         4'd3:    seg_n = SEG_3;
         4'd4:    seg_n = SEG_4;
         4'd5:    seg_n = SEG_5;
         4'd6:    seg_n = SEG_6;
         4'd7:    seg_n = SEG_7;
         4'd8:    seg_n = SEG_8;
         4'd9:    seg_n = SEG_9;
         default: seg_n = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Four-digit multiplexed seven-segment display driver. Holds a BCD digit set
// and decimal points loaded by a strobe, and scans the digits one at a time.
// Each digit slot lasts DIV clocks: one BLANK cycle (all off, to avoid
// ghosting while the anode changes) followed by DIV-1 DRIVE cycles.
//
// Parameters:
//   DIV    clk cycles per digit slot (2..65535)
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous active-low reset
//   ld     in   1   load strobe for din / dp_in
//   din    in   16  four BCD digits, [3:0] = digit0 .. [15:12] = digit3
//   dp_in  in   4   decimal points, active-high, bit i = digit i
//   seg    out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp     out  1   decimal point segment, active-low
//   an     out  4   anode select, active-low, bit i = digit i
//   err    out  1   held digit set contains a nibble greater than 9
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN  when defined, leading zero digits (3..1) are
//                               blanked; digit0 always shows.
//
// All outputs come straight from flops. The output flops are loaded from the
// next-state values, so they always agree with the state registers while no
// combinational path exists from ld/din/dp_in to the pins.
// -----------------------------------------------------------------------------
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned DIV = 1000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ld,
   input  logic [15:0] din,
   input  logic [3:0]  dp_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        err
);

   localparam int unsigned PW         = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   // Held data
   logic [15:0]  digit_q, digit_d;
   logic [3:0]   dpr_q,   dpr_d;
   logic         err_q,   err_d;

   // Scan timing
   logic [PW-1:0] presc_q, presc_d;
   scan_state_e   state_q, state_d;
   logic [1:0]    idx_q,   idx_d;
   logic          tick_s;

   // Output flops
   logic [6:0]   seg_q, seg_d;
   logic         dp_q,  dp_d;
   logic [3:0]   an_q,  an_d;

   // Digit selection for the slot about to be shown
   logic [3:0]   cur_nib_s;
   logic         cur_dp_s;
   logic [6:0]   dec_seg_s;
   logic         lz_blank_s;

   assign tick_s = (presc_q == PRESC_LAST);

   // Digit, decimal-point and error registers: load on ld, hold otherwise.
   always_comb begin
      digit_d = digit_q;
      dpr_d   = dpr_q;
      err_d   = err_q;
      if (ld) begin
         digit_d = din;
         dpr_d   = dp_in;
         err_d   = has_invalid_digit(din);
      end else begin
         digit_d = digit_q;
         dpr_d   = dpr_q;
         err_d   = err_q;
      end
   end

   // Free-running prescaler, wraps to zero after DIV-1.
   always_comb begin
      presc_d = presc_q;
      if (tick_s) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   // Scan FSM next state; the index steps on the edge that enters BLANK so
   // the new anode is first used after the blank gap.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_BLANK: begin
            state_d = ST_DRIVE;
            idx_d   = idx_q;
         end
         ST_DRIVE: begin
            if (tick_s) begin
               state_d = ST_BLANK;
               idx_d   = idx_q + 2'd1;
            end else begin
               state_d = ST_DRIVE;
               idx_d   = idx_q;
            end
         end
         default: begin
            state_d = ST_BLANK;
            idx_d   = 2'd0;
         end
      endcase
   end

   // Pick the nibble and decimal point for the next slot from next-state data
   // so that a load on a tick edge is shown at the very next DRIVE.
   always_comb begin
      cur_nib_s = digit_d[3:0];
      cur_dp_s  = dpr_d[0];
      case (idx_d)
         2'd0: begin
            cur_nib_s = digit_d[3:0];
            cur_dp_s  = dpr_d[0];
         end
         2'd1: begin
            cur_nib_s = digit_d[7:4];
            cur_dp_s  = dpr_d[1];
         end
         2'd2: begin
            cur_nib_s = digit_d[11:8];
            cur_dp_s  = dpr_d[2];
         end
         2'd3: begin
            cur_nib_s = digit_d[15:12];
            cur_dp_s  = dpr_d[3];
         end
         default: begin
            cur_nib_s = digit_d[3:0];
            cur_dp_s  = dpr_d[0];
         end
      endcase
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every higher digit are zero;
   // digit0 is never blanked so a zero value still shows "0".
   always_comb begin
      lz_blank_s = 1'b0;
      case (idx_d)
         2'd3:    lz_blank_s = (digit_d[15:12] == 4'd0);
         2'd2:    lz_blank_s = (digit_d[15:8]  == 8'd0);
         2'd1:    lz_blank_s = (digit_d[15:4]  == 12'd0);
         default: lz_blank_s = 1'b0;
      endcase
   end
`else
   // Leading zeros are displayed.
   always_comb begin
      lz_blank_s = 1'b0;
   end
`endif

   bcd_to_seg7 u_dec (
      .bcd   (cur_nib_s),
      .seg_n (dec_seg_s)
   );

   // Next output values: everything off in BLANK, selected digit in DRIVE.
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (state_d == ST_DRIVE) begin
         an_d = anode_for(idx_d);
         dp_d = ~cur_dp_s;
         if (lz_blank_s) begin
            seg_d = SEG_OFF;
         end else begin
            seg_d = dec_seg_s;
         end
      end else begin
         an_d  = AN_OFF;
         seg_d = SEG_OFF;
         dp_d  = 1'b1;
      end
   end

   // Held data registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit_q <= 16'h0000;
         dpr_q   <= 4'h0;
         err_q   <= 1'b0;
      end else begin
         digit_q <= digit_d;
         dpr_q   <= dpr_d;
         err_q   <= err_d;
      end
   end

   // Scan FSM state, index and prescaler registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_BLANK;
         idx_q   <= 2'd0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         presc_q <= presc_d;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_OFF;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;
   assign err = err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Scoreboard bench for seg7_scan_driver with DIV=4. The stimulus process
// pushes the expected pin values for each clock slot it cares about, tagged
// with the slot number; the monitor samples the pins on every falling edge
// and compares against the entries due for that slot.
// Slot numbering: slot N is the interval after the N-th rising edge.
// With DIV=4, counting from the slot in which reset was released (r0),
// slot r0+k is BLANK when k%4==0, otherwise DRIVE on digit (k/4)%4.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

   localparam int DIV = 4;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        err;

   typedef struct {
      int         stamp;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       err;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   r0     = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.DIV(DIV)) dut (
      .clk   (clk),
      .rst   (rst),
      .ld    (ld),
      .din   (din),
      .dp_in (dp_in),
      .seg   (seg),
      .dp    (dp),
      .an    (an),
      .err   (err)
   );

   // Slot counter.
   initial begin
      forever begin
         @(posedge clk);
         cyc <= cyc + 1;
      end
   end

   // Monitor: compare every expectation that is due at this falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].stamp <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.stamp < cyc) begin
               errors++;
               $display("FAIL %s: slot %0d missed (now slot %0d)", e.tag, e.stamp, cyc);
            end else if (an !== e.an || seg !== e.seg || dp !== e.dp || err !== e.err) begin
               errors++;
               $display("FAIL %s slot %0d: got an=%b seg=%b dp=%b err=%b, expected an=%b seg=%b dp=%b err=%b",
                        e.tag, e.stamp, an, seg, dp, err, e.an, e.seg, e.dp, e.err);
            end
         end
      end
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Leading-zero mask applies only when the blanking option is built in.
   function automatic logic [3:0] lz(input logic [3:0] m);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      return m;
`else
      return m & 4'b0000;
`endif
   endfunction

   task automatic next_slot();
      @(negedge clk);
      #1;
   endtask

   task automatic push_reset(input int stamp, input string tag);
      exp_t x;
      x.stamp = stamp;
      x.an    = 4'hF;
      x.seg   = 7'h7F;
      x.dp    = 1'b1;
      x.err   = 1'b0;
      x.tag   = tag;
      q.push_back(x);
   endtask

   // Push expectations for n consecutive slots starting at 'start'.
   task automatic expect_scan(input int start, input int n,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dpm, input logic e,
                              input logic [3:0] lzm, input string tag);
      for (int k = 0; k < n; k++) begin
         exp_t x;
         int   rel;
         int   ix;
         rel     = start + k - r0;
         ix      = (rel / 4) % 4;
         x.stamp = start + k;
         x.err   = e;
         x.tag   = tag;
         if ((rel % 4) == 0) begin
            x.an  = 4'hF;
            x.seg = 7'h7F;
            x.dp  = 1'b1;
         end else begin
            x.an = 4'hF ^ (4'b0001 << ix);
            x.dp = ~dpm[ix];
            case (ix)
               0:       x.seg = s0;
               1:       x.seg = s1;
               2:       x.seg = s2;
               default: x.seg = s3;
            endcase
            if (lzm[ix]) x.seg = 7'h7F;
         end
         q.push_back(x);
      end
   endtask

   task automatic load(input logic [15:0] d, input logic [3:0] p);
      ld    = 1'b1;
      din   = d;
      dp_in = p;
   endtask

   // Drop ld and let the 16 expected slots of a load play out.
   task automatic finish_load();
      next_slot();
      ld = 1'b0;
      repeat (15) next_slot();
   endtask

   initial begin
      rst   = 1'b0;
      ld    = 1'b0;
      din   = 16'h0000;
      dp_in = 4'h0;

      // Reset held, then released: first DRIVE is digit0 showing '0'.
      next_slot();
      push_reset(cyc + 1, "reset_hold");
      next_slot();
      rst = 1'b1;
      r0  = cyc;
      expect_scan(r0 + 1, 1, S0, S0, S0, S0, 4'b0000, 1'b0, lz(4'b1110), "first_drive");

      // Full scan of 1289 with dp on digit2.
      next_slot();
      load(16'h1289, 4'b0100);
      expect_scan(cyc + 1, 16, S1, S2, S8, S9, 4'b0100, 1'b0, lz(4'b0000), "scan_1289");
      finish_load();

      // Load in the tick cycle: next DRIVE shows the new data, index +1.
      while (((cyc - r0) % 4) != 3) next_slot();
      load(16'h4444, 4'b0000);
      expect_scan(cyc + 1, 8, S4, S4, S4, S4, 4'b0000, 1'b0, lz(4'b0000), "tick_ld_4444");
      finish_load();

      // Leading zeros.
      load(16'h0070, 4'b0000);
      expect_scan(cyc + 1, 16, S0, S0, S7, S0, 4'b0000, 1'b0, lz(4'b1100), "lz_0070");
      finish_load();

      // Invalid nibble sets err and shows a dash; valid load clears err.
      load(16'h00A5, 4'b0000);
      expect_scan(cyc + 1, 16, S0, S0, SD, S5, 4'b0000, 1'b1, lz(4'b1100), "err_00A5");
      finish_load();
      load(16'h0005, 4'b0000);
      expect_scan(cyc + 1, 16, S0, S0, S0, S5, 4'b0000, 1'b0, lz(4'b1110), "err_clear_0005");
      finish_load();

      // All decimal points lit with err set before the mid-scan reset.
      load(16'h9A00, 4'b1111);
      expect_scan(cyc + 1, 16, S9, SD, S0, S0, 4'b1111, 1'b1, lz(4'b0000), "dp_all_9A00");
      finish_load();

      // Reset asserted mid-DRIVE on digit2, checked before the next clk edge.
      while (!((((cyc + 1 - r0) % 4) == 2) && ((((cyc + 1 - r0) / 4) % 4) == 2))) next_slot();
      @(posedge clk);
      #2;
      rst = 1'b0;
      push_reset(cyc, "async_rst_mid_drive");
      next_slot();
      push_reset(cyc + 1, "rst_hold2");
      next_slot();
      rst = 1'b1;
      r0  = cyc;
      expect_scan(r0 + 1, 3, S0, S0, S0, S0, 4'b0000, 1'b0, lz(4'b1110), "restart");

      // Drain the scoreboard with a bound.
      for (int i = 0; i < 20 && q.size() > 0; i++) next_slot();
      next_slot();
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
